seven_seg_ctrl: RTL and testbench
=================================

SEVEN_SEG_CTRL -- requirements
Module: seven_seg_ctrl

Interface
REQ-001 Parameter IO_ADDR, default 32'h0000_0000, word address of the display register.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 io_we  input  1  processor store strobe, one cycle per store.
REQ-005 io_addr  input  32  processor I/O address.
REQ-006 io_data_in  input  32  store data from the processor.
REQ-007 io_data_out  output  32  readback data.
REQ-008 busy  output  1  high while a conversion is pending or in progress.
REQ-009 HEX0..HEX5  output  7 each  segment drives; bit0=a ... bit6=g; active-low; HEX0 is least significant.

Function
REQ-010 A write is accepted when io_we=1 and io_addr==IO_ADDR at a rising edge; other addresses SHALL be ignored.
REQ-011 The accepted 32-bit value SHALL be stored unsigned in value_reg, and io_data_out SHALL equal value_reg combinationally when io_addr==IO_ADDR, else 32'h0.
REQ-012 FSM states: IDLE, CONVERT, UPDATE.
REQ-013 IDLE -> CONVERT on an accepted write; the write edge counts as E0.
REQ-014 CONVERT SHALL run a sequential double-dabble on value[19:0], one shift per edge, exactly 20 edges (E1..E20), using a 5-bit iteration counter.
REQ-015 UPDATE (edge E21) SHALL load all HEX registers from the BCD result; the new glyphs are visible after E21.
REQ-016 busy SHALL be 1 from after E0 through E21, then 0, giving 21 busy cycles per conversion.
REQ-017 A value > 999999 SHALL bypass the BCD result, and UPDATE SHALL drive all six digits to dash 7'b0111111.
REQ-018 Leading-zero blanking: digits above the most significant nonzero digit SHALL be 7'b1111111; value 0 SHALL show "0" on HEX0 only.
REQ-019 Glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 Outputs SHALL be registered and hold their value between UPDATEs; there SHALL be no glitch during CONVERT.
REQ-021 Writes accepted while busy update value_reg, set pending_flag and store pending_val (last write wins); the in-flight conversion SHALL NOT be disturbed.
REQ-022 UPDATE with pending_flag=1 SHALL go directly to CONVERT with pending_val and clear pending_flag; busy SHALL remain 1 with no IDLE cycle.
REQ-023 A write on the same edge as UPDATE SHALL be treated as pending and follow REQ-022.
REQ-024 UPDATE with no pending write SHALL return to IDLE.

Reset
REQ-025 rst=0 SHALL immediately force: state IDLE; value_reg, pending_val, pending_flag, counter and BCD shift register 0; busy 0; HEX0=1000000; HEX1..HEX5=1111111.
REQ-026 Reset asserted mid-conversion SHALL abort the conversion and discard pending data; the first accepted write after release SHALL start a fresh conversion.

Verification
REQ-027 Reset and release -> HEX0=1000000, HEX1..5=1111111, busy=0, io_data_out=0 when io_addr=IO_ADDR.
REQ-028 Write 123456 -> busy high exactly 21 cycles; then HEX5..HEX0 show 1,2,3,4,5,6 (1111001, 0100100, 0110000, 0011001, 0010010, 0000010); readback = 123456.
REQ-029 Write 7, then write 0 after idle -> first HEX0=1111000 with HEX1..5 blank; then HEX0=1000000 with HEX1..5 blank.
REQ-030 Write 1000000 and 32'hFFFF_FFFF in separate transactions -> each yields all six digits 0111111.
REQ-031 Write 42; during busy write 99 then 5 -> display shows 42 after the first 21 cycles, busy stays 1, then shows 5; 99 never displayed; readback = 5.
REQ-032 Write 555 to IO_ADDR+4 -> no busy and no HEX change; write 888 to IO_ADDR and drop rst at cycle 10 of CONVERT -> reset values per REQ-025 and no 888 displayed.

Source files
------------

// File: rtl/seven_seg_ctrl.sv
// Memory-mapped six-digit seven-segment controller: a 32-bit store starts a
// sequential double-dabble conversion, and the result is latched into registered HEX outputs.
module seven_seg_ctrl #(
    parameter logic [31:0] IO_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_we,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_data_in,
    output logic [31:0] io_data_out,
    output logic        busy,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    state_t          state, state_next;
    logic [31:0]     value_reg;
    logic [31:0]     pending_val;
    logic            pending_flag;
    logic [4:0]      iter;
    logic [23:0]     bcd;
    logic [23:0]     bcd_adj;
    logic [19:0]     bin;
    logic            overflow;
    logic [5:0][6:0] hex_q;
    logic [5:0][6:0] disp;
    logic            write_hit;
    logic            load_en;
    logic [31:0]     load_val;
    logic            seen;
    logic [3:0]      digit;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = BLANK;
        endcase
    endfunction

    assign write_hit   = io_we && (io_addr == IO_ADDR);
    assign io_data_out = (io_addr == IO_ADDR) ? value_reg : 32'h0;
    assign busy        = (state != IDLE);

    // A store landing on the UPDATE edge is newer than any queued value, so it wins.
    assign load_en  = ((state == IDLE) && write_hit) ||
                      ((state == UPDATE) && (write_hit || pending_flag));
    assign load_val = write_hit ? io_data_in : pending_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (write_hit) state_next = CONVERT;
            CONVERT: if (iter == 5'd19) state_next = UPDATE;
            UPDATE:  state_next = (write_hit || pending_flag) ? CONVERT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned k = 0; k < 6; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    // Scan from the top digit down; blanking stops at the first nonzero digit, HEX0 always shows.
    always_comb begin
        disp  = '1;
        seen  = 1'b0;
        digit = '0;
        for (int unsigned k = 0; k < 6; k++) begin
            digit = bcd[4*(5-k) +: 4];
            if (overflow) begin
                disp[5-k] = DASH;
            end else if (digit != 4'd0 || seen || k == 5) begin
                disp[5-k] = glyph(digit);
                seen      = 1'b1;
            end else begin
                disp[5-k] = BLANK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_reg    <= '0;
            pending_val  <= '0;
            pending_flag <= 1'b0;
            iter         <= '0;
            bcd          <= '0;
            bin          <= '0;
            overflow     <= 1'b0;
            hex_q        <= {{5{BLANK}}, 7'b1000000};
        end else begin
            if (write_hit) value_reg <= io_data_in;

            if (state == CONVERT) begin
                {bcd, bin} <= {bcd_adj[22:0], bin, 1'b0};
                iter       <= iter + 5'd1;
                if (write_hit) begin
                    pending_flag <= 1'b1;
                    pending_val  <= io_data_in;
                end
            end

            if (state == UPDATE) begin
                hex_q        <= disp;
                pending_flag <= 1'b0;
            end

            if (load_en) begin
                bin      <= load_val[19:0];
                bcd      <= '0;
                iter     <= '0;
                overflow <= (load_val > 32'd999999);
            end
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_seven_seg_ctrl.sv
// Directed bench for seven_seg_ctrl: hand-computed glyph patterns, busy length,
// queued writes, address decode and mid-conversion reset.
module tb_seven_seg_ctrl;

    localparam logic [31:0] IO_ADDR = 32'h0000_1000;

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                           G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                           G6 = 7'b0000010, G7 = 7'b1111000, G9 = 7'b0010000,
                           BL = 7'b1111111, DS = 7'b0111111;

    logic        clk;
    logic        rst;
    logic        io_we;
    logic [31:0] io_addr;
    logic [31:0] io_data_in;
    logic [31:0] io_data_out;
    logic        busy;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [41:0] hexbus;

    int checks = 0;
    int passes = 0;
    int cycles;
    logic saw99 = 1'b0;

    seven_seg_ctrl #(.IO_ADDR(IO_ADDR)) dut (
        .clk(clk), .rst(rst), .io_we(io_we), .io_addr(io_addr),
        .io_data_in(io_data_in), .io_data_out(io_data_out), .busy(busy),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    assign hexbus = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (hexbus[13:0] == {G9, G9}) saw99 = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        io_addr    = addr;
        io_data_in = data;
        io_we      = 1'b1;
        @(negedge clk);
        io_we      = 1'b0;
        io_addr    = IO_ADDR;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic convert(input string tag, input logic [31:0] val, input logic [41:0] exp);
        int n;
        bus_write(IO_ADDR, val);
        wait_idle(n);
        check({tag, "_busy_cycles"}, n, 21);
        check({tag, "_hex"}, hexbus, exp);
    endtask

    initial begin
        rst        = 1'b0;
        io_we      = 1'b0;
        io_addr    = IO_ADDR;
        io_data_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        check("reset_hex", hexbus, {BL, BL, BL, BL, BL, G0});
        check("reset_busy", busy, 1'b0);
        check("reset_readback", io_data_out, 32'h0);

        convert("v123456", 32'd123456, {G1, G2, G3, G4, G5, G6});
        check("v123456_readback", io_data_out, 32'd123456);

        convert("v7", 32'd7, {BL, BL, BL, BL, BL, G7});
        repeat (2) @(negedge clk);
        convert("v0", 32'd0, {BL, BL, BL, BL, BL, G0});
        convert("v1000000", 32'd1000000, {DS, DS, DS, DS, DS, DS});
        convert("vffffffff", 32'hFFFF_FFFF, {DS, DS, DS, DS, DS, DS});

        // 42 in flight, then 99 and 5 queued; the queued 5 must replace 99
        bus_write(IO_ADDR, 32'd42);
        bus_write(IO_ADDR, 32'd99);
        bus_write(IO_ADDR, 32'd5);
        check("q_readback", io_data_out, 32'd5);
        repeat (18) @(negedge clk);
        check("q_busy_before_update", busy, 1'b1);
        check("q_hex_hold", hexbus, {DS, DS, DS, DS, DS, DS});
        @(negedge clk);
        check("q_hex_42", hexbus, {BL, BL, BL, BL, G4, G2});
        check("q_busy_chain", busy, 1'b1);
        wait_idle(cycles);
        check("q_second_busy_cycles", cycles, 21);
        check("q_hex_5", hexbus, {BL, BL, BL, BL, BL, G5});
        check("q_never_99", saw99, 1'b0);

        bus_write(IO_ADDR + 32'd4, 32'd555);
        check("badaddr_busy", busy, 1'b0);
        repeat (25) @(negedge clk);
        check("badaddr_hex", hexbus, {BL, BL, BL, BL, BL, G5});
        check("badaddr_readback", io_data_out, 32'd5);
        io_addr = IO_ADDR + 32'd4;
        #1;
        check("badaddr_readback_other", io_data_out, 32'h0);
        io_addr = IO_ADDR;

        bus_write(IO_ADDR, 32'd888);
        repeat (9) @(negedge clk);
        check("abort_busy_pre", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("abort_hex", hexbus, {BL, BL, BL, BL, BL, G0});
        check("abort_busy", busy, 1'b0);
        check("abort_readback", io_data_out, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_hex_after", hexbus, {BL, BL, BL, BL, BL, G0});
        check("abort_busy_after", busy, 1'b0);

        convert("post_reset_v7", 32'd7, {BL, BL, BL, BL, BL, G7});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
